// File: rtl/hdmi_pkg.sv
// Shared HDMI data island definitions: period encodings, island geometry and
// the scheduler's internal state type.
package hdmi_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL     = 2'd0,
        MODE_PREAMBLE = 2'd1,
        MODE_GUARD    = 2'd2,
        MODE_DATA     = 2'd3
    } island_mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_PREAMBLE,
        S_GUARD_LEAD,
        S_DATA,
        S_GUARD_TRAIL
    } sched_state_t;

    localparam int LEAD_LEN     = 4;
    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;
    localparam int TRAIL_MIN    = 12;

    // Control period length needed to host an island of k packets plus trailing control.
    function automatic int island_min_len(input int k);
        return LEAD_LEN + PREAMBLE_LEN + 2 * GUARD_LEN + TRAIL_MIN + PACKET_LEN * k;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             none
);

    logic [PTR_W-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        none  = 1'b1;
        j     = '0;
        for (int off = 0; off < N; off++) begin
            j = PTR_W'((int'(ptr) + off) % N);
            if (none && req[j]) begin
                none     = 1'b0;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/data_island_scheduler.sv
// Places HDMI data islands inside control periods and round-robins the packet
// path between NUM_SRC sources, one 32-pixel slot per packet.
module data_island_scheduler
    import hdmi_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int MAX_PACKETS = 18,
    parameter int LEN_W       = 12,
    localparam int SRC_W      = $clog2(NUM_SRC + 1)
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic               ctrl_start,
    input  logic [LEN_W-1:0]   ctrl_len,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grant,
    output logic [SRC_W-1:0]   packet_src,
    output logic               assembler_enable,
    output logic [1:0]         island_mode,
    output logic               overrun
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int K_W   = $clog2(MAX_PACKETS + 1);

    sched_state_t     state;
    logic [3:0]       cnt;
    logic [4:0]       slot;
    logic [K_W-1:0]   pkt;
    logic [PTR_W-1:0] ptr;

    int               pop;
    int               k_sel;
    logic [K_W-1:0]   k_new;
    logic [NUM_SRC-1:0] win_grant;
    logic [PTR_W-1:0] win_idx;
    logic             win_none;
    logic             idle_now;
    logic             slot_start;

    // Island size decided on the ctrl_start cycle; the fit test is done in a
    // wide integer so large K never wraps against ctrl_len.
    always_comb begin
        pop = 0;
        for (int i = 0; i < NUM_SRC; i++) pop += int'(req[i]);
        k_sel = 0;
        for (int k = 1; k <= MAX_PACKETS; k++)
            if (int'({1'b0, ctrl_len}) >= island_min_len(k)) k_sel = k;
        if (pop < k_sel) k_sel = pop;
        k_new = K_W'(k_sel);
    end

    rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .none  (win_none)
    );

    // The last GUARD_TRAIL pixel counts as idle so back-to-back control periods work.
    assign idle_now   = (state == S_IDLE) || (state == S_GUARD_TRAIL && cnt == '0);
    // Arbitrate on the pixel before each slot so grant/packet_src are registered on slot pixel 0.
    assign slot_start = (state == S_GUARD_LEAD && cnt == '0) ||
                        (state == S_DATA && slot == 5'(PACKET_LEN - 1) && pkt != '0);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            slot             <= '0;
            pkt              <= '0;
            ptr              <= '0;
            grant            <= '0;
            packet_src       <= SRC_W'(NUM_SRC);
            assembler_enable <= 1'b0;
            island_mode      <= MODE_CTRL;
            overrun          <= 1'b0;
        end else begin
            grant   <= '0;
            overrun <= ctrl_start && !idle_now;

            if (slot_start) begin
                if (win_none) begin
                    packet_src <= SRC_W'(NUM_SRC);
                end else begin
                    grant      <= win_grant;
                    packet_src <= SRC_W'(win_idx);
                    ptr        <= (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (ctrl_start && k_new != '0) begin
                        state <= S_LEAD;
                        cnt   <= 4'(LEAD_LEN - 2);
                        pkt   <= k_new - 1'b1;
                    end
                end
                S_LEAD: begin
                    if (cnt == '0) begin
                        state       <= S_PREAMBLE;
                        cnt         <= 4'(PREAMBLE_LEN - 1);
                        island_mode <= MODE_PREAMBLE;
                    end else cnt <= cnt - 1'b1;
                end
                S_PREAMBLE: begin
                    if (cnt == '0) begin
                        state       <= S_GUARD_LEAD;
                        cnt         <= 4'(GUARD_LEN - 1);
                        island_mode <= MODE_GUARD;
                    end else cnt <= cnt - 1'b1;
                end
                S_GUARD_LEAD: begin
                    if (cnt == '0) begin
                        state            <= S_DATA;
                        slot             <= '0;
                        island_mode      <= MODE_DATA;
                        assembler_enable <= 1'b1;
                    end else cnt <= cnt - 1'b1;
                end
                S_DATA: begin
                    slot <= slot + 5'd1;
                    if (slot == 5'(PACKET_LEN - 1)) begin
                        if (pkt == '0) begin
                            state            <= S_GUARD_TRAIL;
                            cnt              <= 4'(GUARD_LEN - 1);
                            island_mode      <= MODE_GUARD;
                            assembler_enable <= 1'b0;
                        end else pkt <= pkt - 1'b1;
                    end
                end
                S_GUARD_TRAIL: begin
                    if (cnt == '0) begin
                        island_mode <= MODE_CTRL;
                        if (ctrl_start && k_new != '0) begin
                            state <= S_LEAD;
                            cnt   <= 4'(LEAD_LEN - 2);
                            pkt   <= k_new - 1'b1;
                        end else state <= S_IDLE;
                    end else cnt <= cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Bench for data_island_scheduler: directed scenarios plus random traffic,
// checked every pixel against an island-offset reference model.
module tb_data_island_scheduler;

    localparam int NUM_SRC     = 4;
    localparam int MAX_PACKETS = 18;
    localparam int LEN_W       = 12;
    localparam int SRC_W       = $clog2(NUM_SRC + 1);

    logic               clk_pixel = 1'b0;
    logic               reset_n;
    logic               ctrl_start;
    logic [LEN_W-1:0]   ctrl_len;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic [SRC_W-1:0]   packet_src;
    logic               assembler_enable;
    logic [1:0]         island_mode;
    logic               overrun;

    always #5 clk_pixel = ~clk_pixel;

    data_island_scheduler #(
        .NUM_SRC(NUM_SRC), .MAX_PACKETS(MAX_PACKETS), .LEN_W(LEN_W)
    ) dut (
        .clk_pixel        (clk_pixel),
        .reset_n          (reset_n),
        .ctrl_start       (ctrl_start),
        .ctrl_len         (ctrl_len),
        .req              (req),
        .grant            (grant),
        .packet_src       (packet_src),
        .assembler_enable (assembler_enable),
        .island_mode      (island_mode),
        .overrun          (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: island position as a pixel offset from its ctrl_start.
    bit                 m_busy;
    int                 m_n, m_k, m_ptr;
    logic [NUM_SRC-1:0] req_r;
    logic [NUM_SRC-1:0] exp_grant;
    int                 exp_src, exp_mode;
    bit                 exp_en, exp_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        check("island_mode", 32'(island_mode), 32'(exp_mode));
        check("assembler_enable", 32'(assembler_enable), 32'(exp_en));
        check("grant", 32'(grant), 32'(exp_grant));
        check("packet_src", 32'(packet_src), 32'(exp_src));
        check("overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic model_reset();
        m_busy = 0; m_n = 0; m_k = 0; m_ptr = 0;
        exp_grant = '0; exp_src = NUM_SRC; exp_mode = 0; exp_en = 0; exp_ovr = 0;
    endtask

    // Advance the model over the upcoming clock edge using the inputs now applied.
    task automatic model_next();
        int fit, kn, m;
        bit accept;
        accept  = ctrl_start && (!m_busy || m_n == 15 + 32 * m_k);
        exp_ovr = ctrl_start && !accept;
        kn = 0;
        if (accept) begin
            fit = (int'(ctrl_len) >= 28) ? (int'(ctrl_len) - 28) / 32 : 0;
            kn  = $countones(req);
            if (kn > MAX_PACKETS) kn = MAX_PACKETS;
            if (kn > fit) kn = fit;
        end
        if (accept && kn > 0) begin
            m_busy = 1; m_k = kn; m_n = 1;
        end else if (m_busy) begin
            if (m_n == 15 + 32 * m_k) m_busy = 0;
            else m_n++;
        end
        exp_grant = '0;
        if (!m_busy) begin
            exp_mode = 0; exp_en = 0;
        end else begin
            m = m_n;
            if (m < 4) exp_mode = 0;
            else if (m < 12) exp_mode = 1;
            else if (m < 14) exp_mode = 2;
            else if (m < 14 + 32 * m_k) exp_mode = 3;
            else exp_mode = 2;
            exp_en = (exp_mode == 3);
            if (exp_en && (m - 14) % 32 == 0) begin
                exp_src = NUM_SRC;
                for (int off = 0; off < NUM_SRC; off++) begin
                    int j;
                    j = (m_ptr + off) % NUM_SRC;
                    if (exp_src == NUM_SRC && req[j]) begin
                        exp_src = j; exp_grant[j] = 1'b1;
                    end
                end
                if (exp_src != NUM_SRC) m_ptr = (exp_src + 1) % NUM_SRC;
            end
        end
    endtask

    // One pixel: check outputs, apply inputs (served sources drop req), step model.
    task automatic cycle(input bit start, input int len);
        check_outputs();
        req_r      = req_r & ~exp_grant;
        ctrl_start = start;
        ctrl_len   = LEN_W'(len);
        req        = req_r;
        model_next();
        @(negedge clk_pixel);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0);
    endtask

    initial begin
        reset_n = 1'b0; ctrl_start = 1'b0; ctrl_len = '0; req = '0; req_r = '0;
        model_reset();
        repeat (2) @(negedge clk_pixel);
        check_outputs();
        reset_n = 1'b1;

        // single source, one packet
        req_r = 4'b0001; cycle(1, 100); idle(60);
        // four sources, K=4
        req_r = 4'b1111; cycle(1, 156); idle(170);
        // length 91 fits only one packet; the following island continues at source 1
        req_r = 4'b1111; cycle(1, 91); idle(95);
        cycle(1, 91); idle(95);
        req_r = '0; cycle(1, 200); idle(10);
        // withdrawn request gives a null packet
        req_r = 4'b0010; cycle(1, 100); idle(9); req_r = '0; idle(60);
        // overrun inside an island
        req_r = 4'b0001; cycle(1, 100); idle(19); cycle(1, 100); idle(60);
        // ctrl_len 59 is too short; ctrl_len 60 fits exactly one
        req_r = 4'b0100; cycle(1, 59); idle(20); cycle(1, 60); idle(46);
        // ctrl_start on the final GUARD_TRAIL pixel is accepted
        req_r = 4'b1000; cycle(1, 100); idle(60);

        // asynchronous reset mid-DATA
        req_r = 4'b0001; cycle(1, 100); idle(20);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk_pixel);
        reset_n = 1'b1;
        req_r = 4'b0001; cycle(1, 100); idle(60);

        // random traffic
        req_r = '0;
        repeat (4000) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!req_r[i] && $urandom_range(0, 15) == 0) req_r[i] = 1'b1;
                else if (req_r[i] && $urandom_range(0, 199) == 0) req_r[i] = 1'b0;
            end
            cycle($urandom_range(0, 59) == 0, int'($urandom_range(0, 700)));
        end
        idle(650);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
